// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer.
//   WORD_W  : default word width / serial frame length
//   CNT_W   : width of the remaining-bits counter for WORD_W
//   state_e : serializer FSM states
package word_serializer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = $clog2(WORD_W);

    typedef enum logic [0:0] {
        S_IDLE,
        S_SHIFT
    } state_e;

endpackage

// File: rtl/word_serializer_if.sv
// Word input handshake plus serial output bundle of the word serializer.
//   in_data/in_valid/in_ready : word handshake (producer -> serializer)
//   ser_out/ser_active/ser_last : serial stream to the downstream shift register
//   word_ready : pulse when the downstream register holds a complete word
// master = producer/consumer side, slave = serializer side.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_active;
    logic             ser_last;
    logic             word_ready;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_active, ser_last, word_ready
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_active, ser_last, word_ready
    );
endinterface

// File: rtl/word_pend_buf.sv
// Single-entry holding register for the word waiting behind the one being shifted.
//   clk, clr : clock and synchronous active-high clear
//   load_i   : capture data_i and mark valid
//   take_i   : consume the held word (clears valid)
//   data_i   : word to hold
//   data_o   : held word
//   valid_o  : a word is held
module word_pend_buf
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic             take_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // load and take never coincide: loading needs the buffer empty, taking needs it full.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (take_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial stage feeding a free-running 32-bit serial-in shift register.
// Words are accepted over valid/ready and emitted MSB first, one bit per clock.
// A one-entry pending buffer lets consecutive words stream with no idle gap.
//   clk      : system clock, rising edge
//   clr      : synchronous active-high reset (shared with the downstream register)
//   bus      : slave modport -- in_data/in_valid/in_ready handshake,
//              ser_out/ser_active/ser_last serial stream, word_ready pulse
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = WORD_W,
    parameter logic        IDLE_BIT = 1'b0
) (
    input logic               clk,
    input logic               clr,
    word_serializer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             word_ready_q;

    logic             pend_load, pend_take, pend_valid;
    logic [WIDTH-1:0] pend_data;
    logic             accept, last_bit;

    word_pend_buf #(
        .WIDTH (WIDTH)
    ) u_pend (
        .clk     (clk),
        .clr     (clr),
        .load_i  (pend_load),
        .take_i  (pend_take),
        .data_i  (bus.in_data),
        .data_o  (pend_data),
        .valid_o (pend_valid)
    );

    assign bus.in_ready = !clr && !pend_valid;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_bit     = (state_q == S_SHIFT) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        pend_load = 1'b0;
        pend_take = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = bus.in_data;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d   = shreg_q << 1;
                    cnt_d     = cnt_q - 1'b1;
                    pend_load = accept;
                end else if (pend_valid) begin
                    shreg_d   = pend_data;
                    pend_take = 1'b1;
                    cnt_d     = CntW'(WIDTH - 1);
                end else if (accept) begin
                    // Bypass: the word arriving on the final bit goes straight to the shifter.
                    shreg_d = bus.in_data;
                    cnt_d   = CntW'(WIDTH - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            word_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            word_ready_q <= last_bit;
        end
    end

    assign bus.ser_out    = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
    assign bus.ser_active = (state_q == S_SHIFT);
    assign bus.ser_last   = last_bit;
    assign bus.word_ready = word_ready_q;
endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based model of the serial stream and a downstream 32-bit shift register.
module tb_word_serializer;
    import word_serializer_pkg::*;

    localparam int unsigned W = WORD_W;

    logic clk = 1'b0;
    logic clr;

    word_serializer_if #(.WIDTH(W)) bus ();

    word_serializer #(
        .WIDTH    (W),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: words held (front = shifting), bit position within front word.
    logic [W-1:0] m_q[$];
    int           m_pos   = 0;
    bit           m_wr    = 1'b0;
    logic [W-1:0] m_done  = '0;
    bit           m_known = 1'b0;
    logic [W-1:0] ds      = '0;  // downstream serial-in register

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Model and downstream register advance on each rising edge.
    initial begin
        bit acc, last;
        forever begin
            @(posedge clk);
            if (clr) begin
                m_q.delete();
                m_pos   = 0;
                m_wr    = 1'b0;
                m_known = 1'b1;
                ds      = '0;
            end else begin
                ds   = {ds[W-2:0], bus.ser_out};
                acc  = bus.in_valid && (m_q.size() < 2);
                last = (m_q.size() > 0) && (m_pos == W - 1);
                m_wr = last;
                if (last) m_done = m_q[0];
                if (m_q.size() > 0) begin
                    if (m_pos == W - 1) begin
                        void'(m_q.pop_front());
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end
                if (acc) m_q.push_back(bus.in_data);
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        logic [W-1:0] cur;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("in_ready", bus.in_ready, !clr && (m_q.size() < 2));
                chk("word_ready", bus.word_ready, m_wr);
                if (m_wr) chk("downstream_word", ds, m_done);
                if (m_q.size() > 0) begin
                    cur = m_q[0];
                    chk("ser_out", bus.ser_out, cur[W-1-m_pos]);
                    chk("ser_active", bus.ser_active, 1);
                    chk("ser_last", bus.ser_last, m_pos == W - 1);
                end else begin
                    chk("idle_ser_out", bus.ser_out, 0);
                    chk("idle_ser_active", bus.ser_active, 0);
                    chk("idle_ser_last", bus.ser_last, 0);
                end
            end
        end
    end

    initial begin
        int dens;
        clr          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t1_ser_out", bus.ser_out, 0);
            chk("t1_ser_active", bus.ser_active, 0);
            chk("t1_in_ready", bus.in_ready, 1);
            chk("t1_word_ready", bus.word_ready, 0);
            nxt();
        end

        // Single word
        for (int c = 0; c <= 34; c++) begin
            bus.in_valid = (c == 0);
            bus.in_data  = (c == 0) ? 32'h8000_0001 : 32'h0;
            @(negedge clk);
            if (c >= 1 && c <= 32) chk("t2_ser_out", bus.ser_out, (c == 1 || c == 32));
            if (c == 32) chk("t2_ser_last", bus.ser_last, 1);
            chk("t2_word_ready", bus.word_ready, c == 33);
            if (c == 33) chk("t2_downstream", ds, 32'h8000_0001);
            if (c >= 33) chk("t2_ser_active", bus.ser_active, 0);
            nxt();
        end

        // Back-to-back through the pending buffer
        for (int c = 0; c <= 66; c++) begin
            bus.in_valid = (c <= 32);
            bus.in_data  = (c == 0) ? 32'hDEAD_BEEF : (c == 1) ? 32'h1234_5678 : 32'hBAD0_BAD0;
            @(negedge clk);
            if (c == 1) chk("t3_in_ready_c1", bus.in_ready, 1);
            if (c >= 2 && c <= 32) chk("t3_in_ready_busy", bus.in_ready, 0);
            if (c >= 1 && c <= 64) chk("t3_ser_active", bus.ser_active, 1);
            chk("t3_word_ready", bus.word_ready, (c == 33 || c == 65));
            if (c == 33) chk("t3_downstream_1", ds, 32'hDEAD_BEEF);
            if (c == 65) chk("t3_downstream_2", ds, 32'h1234_5678);
            if (c == 66) chk("t3_idle", bus.ser_active, 0);
            nxt();
        end

        // Bypass on the last-bit cycle
        for (int c = 0; c <= 66; c++) begin
            bus.in_valid = (c == 0 || c == 32);
            bus.in_data  = (c == 0) ? 32'hA5A5_A5A5 : (c == 32) ? 32'h0000_FFFF : 32'h0;
            @(negedge clk);
            if (c == 32) chk("t4_in_ready", bus.in_ready, 1);
            if (c == 32) chk("t4_ser_last", bus.ser_last, 1);
            if (c == 33) chk("t4_msb", bus.ser_out, 0);
            if (c >= 1 && c <= 64) chk("t4_ser_active", bus.ser_active, 1);
            chk("t4_word_ready", bus.word_ready, (c == 33 || c == 65));
            if (c == 33) chk("t4_downstream_1", ds, 32'hA5A5_A5A5);
            if (c == 65) chk("t4_downstream_2", ds, 32'h0000_FFFF);
            nxt();
        end

        // clr mid-word with a pending word loaded
        for (int c = 0; c <= 50; c++) begin
            bus.in_valid = (c <= 1 || c == 11);
            bus.in_data  = (c == 0) ? 32'hFFFF_FFFF : (c == 1) ? 32'h5555_AAAA : 32'h7777_7777;
            clr          = (c == 11);
            @(negedge clk);
            if (c == 11) chk("t5_in_ready_clr", bus.in_ready, 0);
            if (c == 12) begin
                chk("t5_ser_active", bus.ser_active, 0);
                chk("t5_ser_out", bus.ser_out, 0);
                chk("t5_in_ready", bus.in_ready, 1);
                chk("t5_downstream", ds, 0);
            end
            if (c >= 2) chk("t5_no_word_ready", bus.word_ready, 0);
            nxt();
        end
        for (int c = 0; c <= 34; c++) begin
            bus.in_valid = (c == 0);
            bus.in_data  = 32'h0000_0003;
            @(negedge clk);
            if (c == 32) chk("t5b_ser_last", bus.ser_last, 1);
            chk("t5b_word_ready", bus.word_ready, c == 33);
            if (c == 33) chk("t5b_downstream", ds, 32'h0000_0003);
            nxt();
        end

        // Randomized traffic with varying load and occasional clr
        dens = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) dens = $urandom_range(5, 100);
            clr          = ($urandom_range(0, 199) == 0);
            bus.in_valid = ($urandom_range(0, 99) < dens);
            bus.in_data  = $urandom;
            nxt();
        end
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (80) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-to-serial stage that feeds the processor's 32-bit serial-in shift register, which shifts on every clock with no enable. Accepts words over a valid/ready handshake and emits one bit per clock, MSB first, so the full word sits in the downstream register after the last shift. A one-entry pending buffer allows back-to-back words with no idle gap. A strobe marks the cycle in which the downstream register holds a complete word.

Parameters:
WIDTH, 32, word width in bits; also the serial frame length.
IDLE_BIT, 1'b0, value driven on ser_out when no word is shifting.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
clr  input  1  synchronous, active-high reset.
in_data  input  WIDTH  word to serialize; sampled only on acceptance.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept; acceptance = in_valid & in_ready at the rising edge.
ser_out  output  1  serial bit to downstream shift-register input.
ser_active  output  1  ser_out carries a data bit this cycle.
ser_last  output  1  ser_out carries bit 0 (the final bit) of the current word.
word_ready  output  1  one-cycle pulse; the downstream register output equals the last completed word.

Behaviour:
- Reset (clr high at an edge): state=IDLE, shreg=0, cnt=0, pend_valid=0, word_ready=0. The next cycle has ser_out=IDLE_BIT, ser_active=0, ser_last=0 and in_ready=1. in_ready is forced to 0 while clr is high, and nothing is accepted.
- State: IDLE and SHIFT. cnt is $clog2(WIDTH) bits wide and counts the remaining bits after the current one.
- in_ready = !clr & !pend_valid, combinational.
- IDLE, on acceptance: shreg<=in_data, cnt<=WIDTH-1, go to SHIFT. Latency: the MSB appears on ser_out in the cycle after acceptance.
- SHIFT outputs: ser_out=shreg[WIDTH-1], ser_active=1, ser_last=(cnt==0).
- SHIFT with cnt!=0, at each edge: shreg<=shreg<<1, cnt<=cnt-1. An acceptance in the same cycle writes the pending buffer (pend<=in_data, pend_valid<=1).
- SHIFT with cnt==0, at the edge (word boundary):
  - If pend_valid: shreg<=pend, pend_valid<=0, cnt<=WIDTH-1, stay in SHIFT.
  - Else if in_valid (in_ready=1): bypass, shreg<=in_data, cnt<=WIDTH-1, stay in SHIFT.
  - Else: go to IDLE.
  - ser_active never drops between consecutive words.
- word_ready: a register set to ser_last each edge. It is high exactly one cycle after each ser_last cycle, and only then.
- Throughput: one word per WIDTH cycles. At most 2 words are held (shreg + pend).
- No acceptance occurs while pend_valid=1. in_data is ignored when not accepted.
- clr mid-word: the word in progress and the pending word are discarded, with no word_ready. The downstream register shares clr and clears in the same cycle.
- IDLE outputs: ser_out=IDLE_BIT, ser_active=0, ser_last=0.

Decomposition:
- Shared package: WORD_W=32, CNT_W=$clog2(WORD_W), and a state enum {S_IDLE, S_SHIFT}.
- One sub-module, word_pend_buf: a single-entry holding register with data, valid, load, take and clr.
- Shift/count logic and the FSM stay in word_serializer.

Test Plan:
1. Reset, then idle with in_valid=0 for 10 cycles -> ser_out=0, ser_active=0, in_ready=1, word_ready=0 throughout.
2. Single word 0x80000001 accepted at cycle 0:
   - ser_out=1 at cycle 1, 0 for cycles 2..31, and 1 at cycle 32 with ser_last=1.
   - word_ready=1 at cycle 33, when the downstream register out equals 0x80000001.
   - ser_active=0 from cycle 33.
3. in_valid held with 0xDEADBEEF then 0x12345678:
   - The first word is accepted at cycle 0 and the second at cycle 1 into pend.
   - in_ready=0 for cycles 2..32.
   - ser_active is continuous for cycles 1..64.
   - word_ready fires at 33 (downstream=0xDEADBEEF) and at 65 (downstream=0x12345678).
4. Bypass: 0xA5A5A5A5 accepted at cycle 0, then 0x0000FFFF presented only at cycle 32 (ser_last cycle) -> it is accepted immediately and its MSB (0) appears at cycle 33 with no gap. word_ready fires at 33 and 65.
5. clr asserted at cycle 11 during word 0xFFFFFFFF with a pending word loaded:
   - Cycle 12 shows IDLE outputs and in_ready=1, and the downstream register is 0.
   - No word_ready pulse occurs.
   - A new word 0x00000003 then completes normally, with word_ready 33 cycles after its acceptance.
